// File: rtl/xge_stats_counters_if.sv
// Event, clear-strobe and counter-readout signals between the packet engines,
// the CPU register block and the statistics accumulator.
interface xge_stats_counters_if #(
  parameter int LEN_W = 16
);
  logic             tx_pkt_done;
  logic [LEN_W-1:0] tx_pkt_len;
  logic             rx_pkt_done;
  logic [LEN_W-1:0] rx_pkt_len;
  logic             rx_pkt_bad;
  logic             clear_stats_tx_octets;
  logic             clear_stats_tx_pkts;
  logic             clear_stats_rx_octets;
  logic             clear_stats_rx_pkts;
  logic [31:0]      stats_tx_octets;
  logic [31:0]      stats_tx_pkts;
  logic [31:0]      stats_rx_octets;
  logic [31:0]      stats_rx_pkts;

  modport master (
    output tx_pkt_done, tx_pkt_len, rx_pkt_done, rx_pkt_len, rx_pkt_bad,
    output clear_stats_tx_octets, clear_stats_tx_pkts,
    output clear_stats_rx_octets, clear_stats_rx_pkts,
    input  stats_tx_octets, stats_tx_pkts, stats_rx_octets, stats_rx_pkts
  );

  modport slave (
    input  tx_pkt_done, tx_pkt_len, rx_pkt_done, rx_pkt_len, rx_pkt_bad,
    input  clear_stats_tx_octets, clear_stats_tx_pkts,
    input  clear_stats_rx_octets, clear_stats_rx_pkts,
    output stats_tx_octets, stats_tx_pkts, stats_rx_octets, stats_rx_pkts
  );
endinterface

// File: rtl/xge_stats_counters.sv
// Four 32-bit MAC traffic counters fed by a capture stage per direction, with
// clear-on-read that keeps the event sitting in the capture stage.
module xge_stats_counters #(
  parameter int LEN_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  xge_stats_counters_if.slave   bus
);

  localparam int NUM_CNT = 4;

  logic             tx_valid_reg;
  logic [LEN_W-1:0] tx_len_reg;
  logic             rx_valid_reg;
  logic [LEN_W-1:0] rx_len_reg;

  logic [31:0] amount    [NUM_CNT];
  logic        clear     [NUM_CNT];
  logic [31:0] cnt_reg   [NUM_CNT];
  logic [31:0] cnt_next  [NUM_CNT];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      tx_valid_reg <= 1'b0;
      tx_len_reg   <= '0;
      rx_valid_reg <= 1'b0;
      rx_len_reg   <= '0;
    end else begin
      tx_valid_reg <= bus.tx_pkt_done;
      tx_len_reg   <= bus.tx_pkt_len;
      // Bad RX frames are dropped here so neither RX counter ever sees them.
      rx_valid_reg <= bus.rx_pkt_done & ~bus.rx_pkt_bad;
      rx_len_reg   <= bus.rx_pkt_len;
    end
  end

  // Index order: 0 tx octets, 1 tx packets, 2 rx octets, 3 rx packets.
  always_comb begin
    amount[0] = tx_valid_reg ? {{(32-LEN_W){1'b0}}, tx_len_reg} : 32'd0;
    amount[1] = {31'd0, tx_valid_reg};
    amount[2] = rx_valid_reg ? {{(32-LEN_W){1'b0}}, rx_len_reg} : 32'd0;
    amount[3] = {31'd0, rx_valid_reg};
    clear[0]  = bus.clear_stats_tx_octets;
    clear[1]  = bus.clear_stats_tx_pkts;
    clear[2]  = bus.clear_stats_rx_octets;
    clear[3]  = bus.clear_stats_rx_pkts;
  end

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [32:0] sum;

      assign sum = {1'b0, cnt_reg[gi]} + {1'b0, amount[gi]};

      // A clear replaces the count with this cycle's contribution, so the
      // value the reader sampled is exactly what gets removed.
      always_comb begin
        cnt_next[gi] = sum[31:0];
        if (clear[gi]) begin
          cnt_next[gi] = amount[gi];
        end else if (sum[32] && (SATURATE != 0)) begin
          cnt_next[gi] = 32'hFFFF_FFFF;
        end
      end

      always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
          cnt_reg[gi] <= 32'd0;
        end else begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  assign bus.stats_tx_octets = cnt_reg[0];
  assign bus.stats_tx_pkts   = cnt_reg[1];
  assign bus.stats_rx_octets = cnt_reg[2];
  assign bus.stats_rx_pkts   = cnt_reg[3];

endmodule

// File: tb/tb_xge_stats_counters.sv
// Randomized and directed scoreboard bench for xge_stats_counters; drives a
// saturating and a wrapping instance with identical stimulus.
module tb_xge_stats_counters;
  localparam int LW = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xge_stats_counters_if #(.LEN_W(LW)) bus_s ();
  xge_stats_counters_if #(.LEN_W(LW)) bus_w ();

  xge_stats_counters #(.LEN_W(LW), .SATURATE(1)) dut_sat (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus_s.slave)
  );

  xge_stats_counters #(.LEN_W(LW), .SATURATE(0)) dut_wrap (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus_w.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef logic [127:0] snap_t;
  snap_t q_s[$];
  snap_t q_w[$];

  // Reference state: counters per instance (0 = saturating, 1 = wrapping)
  // plus the event accepted on the previous edge, still awaiting accumulation.
  longint unsigned m_cnt [2][4];
  bit              p_tx_v, p_rx_v;
  longint unsigned p_tx_l, p_rx_l;

  bit              c_rst_n, c_tx_d, c_rx_d, c_rx_b;
  longint unsigned c_tx_l, c_rx_l;
  logic [3:0]      c_clr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    longint unsigned contrib [4];
    longint unsigned s;
    if (!c_rst_n) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++) m_cnt[d][i] = 0;
      p_tx_v = 0; p_rx_v = 0; p_tx_l = 0; p_rx_l = 0;
      return;
    end
    contrib[0] = p_tx_v ? p_tx_l : 0;
    contrib[1] = p_tx_v ? 1 : 0;
    contrib[2] = p_rx_v ? p_rx_l : 0;
    contrib[3] = p_rx_v ? 1 : 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (c_clr[i]) begin
          m_cnt[d][i] = contrib[i];
        end else begin
          s = m_cnt[d][i] + contrib[i];
          if (s > 64'hFFFF_FFFF) s = (d == 0) ? 64'hFFFF_FFFF : (s & 64'hFFFF_FFFF);
          m_cnt[d][i] = s;
        end
      end
    end
    p_tx_v = c_tx_d;
    p_tx_l = c_tx_l;
    p_rx_v = c_rx_d && !c_rx_b;
    p_rx_l = c_rx_l;
  endfunction

  function automatic snap_t snap(input int d);
    return {m_cnt[d][0][31:0], m_cnt[d][1][31:0], m_cnt[d][2][31:0], m_cnt[d][3][31:0]};
  endfunction

  task automatic step(input bit rstn, input bit txd, input longint unsigned txl,
                      input bit rxd, input longint unsigned rxl, input bit rxb,
                      input logic [3:0] clr);
    c_rst_n = rstn; c_tx_d = txd; c_tx_l = txl; c_rx_d = rxd; c_rx_l = rxl;
    c_rx_b = rxb; c_clr = clr;
    rst_n = rstn;
    bus_s.tx_pkt_done = txd;  bus_w.tx_pkt_done = txd;
    bus_s.tx_pkt_len  = txl[LW-1:0]; bus_w.tx_pkt_len = txl[LW-1:0];
    bus_s.rx_pkt_done = rxd;  bus_w.rx_pkt_done = rxd;
    bus_s.rx_pkt_len  = rxl[LW-1:0]; bus_w.rx_pkt_len = rxl[LW-1:0];
    bus_s.rx_pkt_bad  = rxb;  bus_w.rx_pkt_bad = rxb;
    bus_s.clear_stats_tx_octets = clr[0]; bus_w.clear_stats_tx_octets = clr[0];
    bus_s.clear_stats_tx_pkts   = clr[1]; bus_w.clear_stats_tx_pkts   = clr[1];
    bus_s.clear_stats_rx_octets = clr[2]; bus_w.clear_stats_rx_octets = clr[2];
    bus_s.clear_stats_rx_pkts   = clr[3]; bus_w.clear_stats_rx_pkts   = clr[3];
    @(posedge clk);
    model_edge();
    q_s.push_back(snap(0));
    q_w.push_back(snap(1));
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 4'b0000);
  endtask

  // Monitor: one scoreboard entry per edge, compared mid-cycle.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        chk("sat_tx_octets", bus_s.stats_tx_octets, e[127:96]);
        chk("sat_tx_pkts",   bus_s.stats_tx_pkts,   e[95:64]);
        chk("sat_rx_octets", bus_s.stats_rx_octets, e[63:32]);
        chk("sat_rx_pkts",   bus_s.stats_rx_pkts,   e[31:0]);
      end
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        chk("wrap_tx_octets", bus_w.stats_tx_octets, e[127:96]);
        chk("wrap_tx_pkts",   bus_w.stats_tx_pkts,   e[95:64]);
        chk("wrap_rx_octets", bus_w.stats_rx_octets, e[63:32]);
        chk("wrap_rx_pkts",   bus_w.stats_rx_pkts,   e[31:0]);
      end
    end
  end

  initial begin
    bit txd, rxd, rxb, rstn;
    longint unsigned txl, rxl;
    logic [3:0] clr;

    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 4'b0000);
    chk("reset_tx_octets", bus_s.stats_tx_octets, 32'd0);
    chk("reset_tx_pkts",   bus_s.stats_tx_pkts,   32'd0);
    chk("reset_rx_octets", bus_s.stats_rx_octets, 32'd0);
    chk("reset_rx_pkts",   bus_s.stats_rx_pkts,   32'd0);

    step(1, 1, 64, 0, 0, 0, 4'b0000);
    step(1, 1, 1518, 0, 0, 0, 4'b0000);
    step(1, 1, 9000, 0, 0, 0, 4'b0000);
    idle(2);
    chk("tx3_pkts",   bus_s.stats_tx_pkts,   32'd3);
    chk("tx3_octets", bus_s.stats_tx_octets, 32'd10582);
    chk("tx3_rx_pkts_zero", bus_s.stats_rx_pkts, 32'd0);

    step(1, 0, 0, 1, 100, 0, 4'b0000);
    step(1, 0, 0, 1, 200, 1, 4'b0000);
    step(1, 0, 0, 1, 300, 0, 4'b0000);
    idle(2);
    chk("rx_good_pkts",   bus_s.stats_rx_pkts,   32'd2);
    chk("rx_good_octets", bus_s.stats_rx_octets, 32'd400);

    step(0, 0, 0, 0, 0, 0, 4'b0000);
    step(1, 1, 1000, 0, 0, 0, 4'b0000);
    idle(2);
    chk("preclear_tx_octets", bus_s.stats_tx_octets, 32'd1000);
    step(1, 1, 60, 0, 0, 0, 4'b0000);
    chk("clear_cycle_sample", bus_s.stats_tx_octets, 32'd1000);
    step(1, 0, 0, 0, 0, 0, 4'b0001);
    chk("clear_keeps_inflight", bus_s.stats_tx_octets, 32'd60);
    chk("clear_pkts_untouched", bus_s.stats_tx_pkts,   32'd2);

    step(1, 0, 0, 1, 10, 0, 4'b0000);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 10, 0, 4'b1000);
    chk("hold_clear_rx_pkts", bus_s.stats_rx_pkts, 32'd1);
    step(1, 0, 0, 1, 10, 0, 4'b0000);
    chk("after_clear_inc1", bus_s.stats_rx_pkts, 32'd2);
    idle(1);
    chk("after_clear_inc2", bus_s.stats_rx_pkts, 32'd3);

    step(1, 1, 77, 0, 0, 0, 4'b0000);
    step(0, 1, 55, 0, 0, 0, 4'b0000);
    chk("rst_tx_octets", bus_s.stats_tx_octets, 32'd0);
    chk("rst_rx_pkts",   bus_w.stats_rx_pkts,   32'd0);
    idle(2);
    chk("rst_drops_inflight", bus_s.stats_tx_octets, 32'd0);
    chk("rst_drops_pkts",     bus_s.stats_tx_pkts,   32'd0);

    for (int k = 0; k < 256; k++) step(1, 0, 0, 1, 24'hFF_FFFF, 0, 4'b0000);
    step(1, 0, 0, 1, 65535, 0, 4'b0000);
    step(1, 0, 0, 1, 65535, 0, 4'b0000);
    idle(2);
    chk("sat_rx_octets_top", bus_s.stats_rx_octets, 32'hFFFF_FFFF);
    chk("wrap_rx_octets_low", bus_w.stats_rx_octets, 32'h0001_FEFE);
    chk("sat_rx_pkts_258", bus_s.stats_rx_pkts, 32'd258);
    step(1, 0, 0, 1, 1, 0, 4'b0000);
    idle(2);
    chk("sat_holds", bus_s.stats_rx_octets, 32'hFFFF_FFFF);

    for (int k = 0; k < 1500; k++) begin
      rstn = ($urandom_range(0, 99) != 0);
      txd  = ($urandom_range(0, 9) < 6);
      rxd  = ($urandom_range(0, 9) < 6);
      rxb  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 19))
        0, 1:    txl = 0;
        2:       txl = 24'hFF_FFFF;
        default: txl = $urandom_range(0, 24'hFF_FFFF);
      endcase
      case ($urandom_range(0, 19))
        0, 1:    rxl = 0;
        2:       rxl = 24'hFF_FFFF;
        default: rxl = $urandom_range(0, 24'hFF_FFFF);
      endcase
      for (int i = 0; i < 4; i++) clr[i] = ($urandom_range(0, 19) == 0);
      step(rstn, txd, txl, rxd, rxl, rxb, clr);
    end

    idle(2);
    @(negedge clk);
    #1;
    n_tests++;
    if (q_s.size() != 0 || q_w.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d entries left expected 0", q_s.size(), q_w.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xge_stats_counters.md
Name: xge_stats_counters

Overview:
- Statistics accumulator that owns the four 32-bit MAC traffic counters: TX octets, TX packets, RX octets, RX packets.
- Sits between the TX/RX packet engines and the Wishbone register interface. It consumes one-cycle per-packet completion pulses with byte counts.
- It drives the stats_* buses read by the CPU register block, and applies that block's clear-on-read strobes without losing events that arrive in the same cycle.

Parameters:
- LEN_W, 16, width of the per-packet byte-count inputs; must be 1..31.
- SATURATE, 1, 1 = counters stick at 32'hFFFF_FFFF; 0 = counters wrap modulo 2^32.

Ports:
- wb_clk_i  input  1  single clock for the block; all logic on its rising edge.
- wb_rst_n  input  1  reset, synchronous, active-low.
- tx_pkt_done  input  1  one-cycle pulse: a TX frame completed.
- tx_pkt_len  input  LEN_W  TX frame byte count; qualified by tx_pkt_done.
- rx_pkt_done  input  1  one-cycle pulse: an RX frame completed.
- rx_pkt_len  input  LEN_W  RX frame byte count; qualified by rx_pkt_done.
- rx_pkt_bad  input  1  qualified by rx_pkt_done; 1 = frame had CRC, fragment or length error.
- clear_stats_tx_octets  input  1  clear-on-read strobe; may stay high for several consecutive cycles.
- clear_stats_tx_pkts  input  1  as above, for the TX packet counter.
- clear_stats_rx_octets  input  1  as above, for the RX octet counter.
- clear_stats_rx_pkts  input  1  as above, for the RX packet counter.
- stats_tx_octets  output  32  TX octet counter.
- stats_tx_pkts  output  32  TX packet counter.
- stats_rx_octets  output  32  RX good-frame octet counter.
- stats_rx_pkts  output  32  RX good-frame packet counter.

Behaviour:
- Reset:
  - While wb_rst_n=0 at a rising edge: all four stats_* outputs become 0, and both pipeline stage registers have valid=0 with amounts 0.
  - Reset overrides clears and events in the same cycle.
  - An event pulsed during the reset cycle is dropped.
- Pipeline: two stages per direction, TX and RX independent.
  - Stage 1 (capture): registers {valid, len} from the done pulse and len input.
  - For RX, stage-1 valid = rx_pkt_done & ~rx_pkt_bad. Bad frames are never counted in either RX counter.
  - Stage 2 (accumulate): if stage-1 valid, octet counter += zero-extended len and packet counter += 1.
  - Latency: a pulse in cycle N is first visible on the stats_* outputs after the edge ending cycle N+1.
  - Throughput: one event per direction per cycle, back-to-back pulses allowed.
- Arithmetic:
  - Each add is 33-bit: {1'b0,counter} + zero-extended amount.
  - SATURATE=1: if bit 32 of the sum is set, the result is 32'hFFFF_FFFF; a saturated counter stays saturated until cleared.
  - SATURATE=0: keep bits [31:0] (wrap).
  - A len of 0 with valid set still increments the packet counter by 1 and adds 0 octets.
- Clear (per counter, independent):
  - When clear_x=1 at an edge, counter_x <= amount contributed by stage 1 this cycle (0 if stage 1 is not valid); otherwise counter_x <= counter_x + contribution.
  - Consequence: the value the register block samples in the clear cycle is exactly what was removed. An event in flight in stage 1 during the clear cycle survives into the fresh count; no event is lost or double-counted.
  - A clear held for K cycles: each cycle re-applies the rule above.
  - Clearing the octet counter does not affect the packet counter of the same direction, and vice versa.
- Simultaneous events:
  - TX and RX events in the same cycle are both counted.
  - A clear plus an event for the same counter in the same cycle follows the clear rule above.
- Outputs are direct register outputs; there is no combinational path from any input to any output.

Test Plan:
- Reset, then three back-to-back tx_pkt_done pulses with len 64, 1518, 9000 -> stats_tx_pkts=3 and stats_tx_octets=10582, both stable 2 cycles after the last pulse; RX counters stay 0.
- rx_pkt_done pulses: len 100 good, 200 bad, 300 good -> stats_rx_pkts=2 and stats_rx_octets=400.
- stats_tx_octets=1000; pulse tx_pkt_done len 60 in cycle N; assert clear_stats_tx_octets in cycle N+1 only -> stats_tx_octets=1000 during N+1 (the sampled value), and 60 after the N+1 edge. stats_tx_pkts is unaffected and increments by 1.
- SATURATE=1: preload by pulsing until stats_rx_octets >= 32'hFFFF_0000, then add len 65535 twice -> 32'hFFFF_FFFF and holds. Same sequence with SATURATE=0 -> the wrapped low 32 bits.
- clear_stats_rx_pkts held 3 cycles while a good RX pulse arrives every cycle -> stats_rx_pkts=1 after the last clear edge, then increments by 1 per cycle.
- Assert wb_rst_n=0 for one cycle while stats_tx_octets is nonzero and a tx pulse is in stage 1 -> all outputs 0 after that edge; the in-flight event is not counted.
